pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port SYS_clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port SYS_reset, input, 1, reset; asynchronous, active-high.
REQ-003 SHALL have port run_mode, input, 1, level; 1 = free-run request, 0 = stop request.
REQ-004 SHALL have port step_req, input, 1, single-cycle pulse; request one pipeline advance.
REQ-005 SHALL have port pc_load, input, 1, request to load PC from pc_load_val.
REQ-006 SHALL have port pc_load_val, input, 8, PC value to load.
REQ-007 SHALL have ports ID_rs and ID_rt, input, 5 each, source registers of the instruction in ID.
REQ-008 SHALL have ports EX_MemRead (input, 1) and EX_rt (input, 5), load flag and destination of the instruction in EX.
REQ-009 SHALL have port ID_exception, input, 1, the control decoder has flagged the instruction in ID as illegal.
REQ-010 SHALL have ports MEM_branch_taken (input, 1) and MEM_branch_addr (input, 8), branch resolution in MEM.
REQ-011 SHALL have port PC, output, 8, instruction fetch address (register owned by this block).
REQ-012 SHALL have ports IF_ID_en, ID_EX_en, pipe_en, output, 1 each, write enables for IF/ID, ID/EX, and EX/MEM plus MEM/WB.
REQ-013 SHALL have ports IF_ID_flush, ID_EX_flush, EX_MEM_flush, output, 1 each, synchronous clear to bubble; flush overrides enable.
REQ-014 SHALL have ports state, output, 2 (IDLE=0, RUN=1, STEP=2, HALT=3), and stall_cnt, output, 8.

Function
REQ-015 SHALL implement a 4-state FSM; "advance" = state is RUN or STEP.
REQ-016 SHALL, in IDLE: pc_load -> PC<=pc_load_val, assert all three flushes, stay IDLE; else run_mode=1 -> RUN; else step_req=1 -> STEP; else stay.
REQ-017 SHALL, in IDLE, give pc_load priority over run_mode, and run_mode priority over step_req.
REQ-018 SHALL, in RUN: ID_exception (no taken branch) -> HALT; else run_mode=0 -> IDLE; else stay.
REQ-019 SHALL, in STEP, advance exactly one cycle, then go to IDLE (or to HALT if ID_exception fires in that cycle with no taken branch).
REQ-020 SHALL, in HALT, deassert all enables; only pc_load exits HALT, doing the same load and flush as in IDLE, next state IDLE.
REQ-021 SHALL ignore pc_load in RUN and STEP, and ignore step_req outside IDLE.
REQ-022 SHALL, in IDLE and HALT without a load, deassert all enables and flushes, holding PC.
REQ-023 SHALL, on a normal advance cycle, assert all enables and set PC<=PC+1, wrapping 8'hFF -> 8'h00.
REQ-024 SHALL detect load-use as EX_MemRead=1, EX_rt!=0, and EX_rt equal to ID_rs or ID_rt.
REQ-025 SHALL, on load-use during advance: hold PC, deassert IF_ID_en, assert ID_EX_flush, assert pipe_en, and increment stall_cnt (saturating at 255).
REQ-026 SHALL, on MEM_branch_taken during advance: PC<=MEM_branch_addr, assert IF_ID_flush, ID_EX_flush and EX_MEM_flush, assert pipe_en; this has top priority, suppressing load-use and exception.
REQ-027 SHALL, on ID_exception during advance with no taken branch: hold PC, deassert IF_ID_en, assert ID_EX_flush and pipe_en; load-use is not counted in that cycle.
REQ-028 SHALL produce enables and flushes combinationally from state and current inputs; PC, state and stall_cnt SHALL be registered.
REQ-029 SHALL never assert any flush or enable output with X; all outputs SHALL be defined every cycle.

Reset
REQ-030 SHALL, while SYS_reset=1, force state=IDLE, PC=0 and stall_cnt=0 immediately (no clock required).
REQ-031 SHALL, while SYS_reset=1, hold all enables at 0 and all flushes at 1.
REQ-032 SHALL, on reset asserted mid-RUN or mid-STEP, discard any pending transition, and return to IDLE on release.

Verification
REQ-033 SHALL cover: reset, run_mode=1 for 4 cycles -> PC=1,2,3,4; state RUN; all enables 1.
REQ-034 SHALL cover: PC=8'hFF in RUN, one cycle -> PC=8'h00.
REQ-035 SHALL cover: in RUN with EX_MemRead=1, EX_rt=5, ID_rt=5 for 1 cycle -> PC held, IF_ID_en=0, ID_EX_flush=1, stall_cnt 0->1; EX_rt=0 with the same inputs -> no stall.
REQ-036 SHALL cover: MEM_branch_taken=1, addr=8'h40, plus load-use and ID_exception in the same cycle -> PC=8'h40, three flushes, state stays RUN, stall_cnt unchanged.
REQ-037 SHALL cover: IDLE, step_req pulse -> exactly one PC increment, state STEP then IDLE; run_mode=1 and step_req together -> RUN.
REQ-038 SHALL cover: ID_exception in RUN -> HALT with enables 0; pc_load with val=8'h10 -> PC=8'h10, flushes for 1 cycle, IDLE; asynchronous reset mid-HALT -> PC=0, IDLE.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: run/step/halt sequencer for a five-stage pipeline.
// Owns the fetch PC, generates per-stage write enables and bubble flushes,
// stalls on load-use hazards and redirects on branches resolved in MEM.
//
// Stage control semantics: an enable lets the stage register capture new
// data on the next rising edge; a flush clears the stage register to a
// bubble on that same edge and takes precedence over its enable. Both are
// plain combinational functions of the registered state and this cycle's
// inputs; no handshake back-pressure exists beyond them.
module pipe_ctrl (
    input  logic       SYS_clk,
    input  logic       SYS_reset,
    input  logic       run_mode,
    input  logic       step_req,
    input  logic       pc_load,
    input  logic [7:0] pc_load_val,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       EX_MemRead,
    input  logic [4:0] EX_rt,
    input  logic       ID_exception,
    input  logic       MEM_branch_taken,
    input  logic [7:0] MEM_branch_addr,
    output logic [7:0] PC,
    output logic       IF_ID_en,
    output logic       ID_EX_en,
    output logic       pipe_en,
    output logic       IF_ID_flush,
    output logic       ID_EX_flush,
    output logic       EX_MEM_flush,
    output logic [1:0] state,
    output logic [7:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] stall_cnt_q, stall_cnt_d;

    logic if_id_en_c, id_ex_en_c, pipe_en_c;
    logic if_id_flush_c, id_ex_flush_c, ex_mem_flush_c;

    logic advance;
    logic load_use;

    // Hazard qualifiers: pipeline advances only in RUN/STEP; register 0 never creates a dependency.
    always_comb begin
        advance  = (state_q == ST_RUN) || (state_q == ST_STEP);
        load_use = EX_MemRead && (EX_rt != 5'd0) &&
                   ((EX_rt == ID_rs) || (EX_rt == ID_rt));
    end

    // Next-state, PC, stall counter and stage controls; branch beats exception beats load-use.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        stall_cnt_d    = stall_cnt_q;
        if_id_en_c     = 1'b0;
        id_ex_en_c     = 1'b0;
        pipe_en_c      = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_flush_c  = 1'b0;
        ex_mem_flush_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pc_load) begin
                    pc_d           = pc_load_val;
                    if_id_flush_c  = 1'b1;
                    id_ex_flush_c  = 1'b1;
                    ex_mem_flush_c = 1'b1;
                end else if (run_mode) begin
                    state_d = ST_RUN;
                end else if (step_req) begin
                    state_d = ST_STEP;
                end
            end
            ST_HALT: begin
                if (pc_load) begin
                    pc_d           = pc_load_val;
                    if_id_flush_c  = 1'b1;
                    id_ex_flush_c  = 1'b1;
                    ex_mem_flush_c = 1'b1;
                    state_d        = ST_IDLE;
                end
            end
            default: begin
                // RUN or STEP: a STEP always lasts exactly one advance cycle.
                if (state_q == ST_STEP) begin
                    state_d = ST_IDLE;
                end else if (!run_mode) begin
                    state_d = ST_IDLE;
                end

                if (MEM_branch_taken) begin
                    pc_d           = MEM_branch_addr;
                    if_id_en_c     = 1'b1;
                    id_ex_en_c     = 1'b1;
                    pipe_en_c      = 1'b1;
                    if_id_flush_c  = 1'b1;
                    id_ex_flush_c  = 1'b1;
                    ex_mem_flush_c = 1'b1;
                end else if (ID_exception) begin
                    id_ex_en_c    = 1'b1;
                    pipe_en_c     = 1'b1;
                    id_ex_flush_c = 1'b1;
                    state_d       = ST_HALT;
                end else if (load_use) begin
                    id_ex_en_c    = 1'b1;
                    pipe_en_c     = 1'b1;
                    id_ex_flush_c = 1'b1;
                    if (stall_cnt_q != 8'hFF) begin
                        stall_cnt_d = stall_cnt_q + 8'd1;
                    end
                end else begin
                    pc_d       = pc_q + 8'd1;
                    if_id_en_c = 1'b1;
                    id_ex_en_c = 1'b1;
                    pipe_en_c  = 1'b1;
                end
            end
        endcase
    end

    // State, PC and stall counter registers with asynchronous reset.
    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= 8'h00;
            stall_cnt_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Outputs; reset holds every stage frozen and flushed without waiting for a clock.
    always_comb begin
        IF_ID_en     = SYS_reset ? 1'b0 : if_id_en_c;
        ID_EX_en     = SYS_reset ? 1'b0 : id_ex_en_c;
        pipe_en      = SYS_reset ? 1'b0 : pipe_en_c;
        IF_ID_flush  = SYS_reset ? 1'b1 : if_id_flush_c;
        ID_EX_flush  = SYS_reset ? 1'b1 : id_ex_flush_c;
        EX_MEM_flush = SYS_reset ? 1'b1 : ex_mem_flush_c;
        PC           = pc_q;
        state        = state_q;
        stall_cnt    = stall_cnt_q;
    end

endmodule
